// File: rtl/stream_loader_pkg.sv
// rtl/stream_loader_pkg.sv - shared types and width helpers for the HBM stream loader
package stream_loader_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        DRAIN   = 2'd2,
        DONE_CH = 2'd3
    } ch_state_e;

    localparam int DEFAULT_MAX_OUTSTANDING = 32;

    // Credit/occupancy counters must represent MAX_OUTSTANDING itself, hence the extra bit.
    function automatic int credit_width(input int max_outstanding);
        return $clog2(max_outstanding) + 1;
    endfunction

    function automatic int ptr_width(input int max_outstanding);
        return (max_outstanding > 1) ? $clog2(max_outstanding) : 1;
    endfunction

endpackage

// File: rtl/stream_loader_channel.sv
// rtl/stream_loader_channel.sv - one pseudo-channel: request issue, credits, response FIFO, dispatch tagging
module stream_loader_channel
    import stream_loader_pkg::*;
#(
    parameter int HBM_AWIDTH       = 28,
    parameter int HBM_DWIDTH       = 256,
    parameter int LEN_WIDTH        = 16,
    parameter int DISPATCHER_WIDTH = 1,
    parameter int MAX_OUTSTANDING  = DEFAULT_MAX_OUTSTANDING
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_acc_i,
    input  logic                        global_done_i,
    input  logic [HBM_AWIDTH-1:0]       base_addr_i,
    input  logic [LEN_WIDTH-1:0]        length_i,
    output logic                        ch_done_o,
    output logic [HBM_AWIDTH-1:0]       req_addr_o,
    output logic                        req_valid_o,
    input  logic                        ctrl_full_i,
    input  logic [HBM_DWIDTH-1:0]       rsp_data_i,
    input  logic                        rsp_valid_i,
    output logic [HBM_DWIDTH-1:0]       disp_data_o,
    output logic [DISPATCHER_WIDTH-1:0] disp_counter_o,
    output logic                        disp_valid_o,
    input  logic                        disp_ready_i
);

    localparam int CW = credit_width(MAX_OUTSTANDING);
    localparam int PW = ptr_width(MAX_OUTSTANDING);

    ch_state_e                   state_q, state_d;
    logic [LEN_WIDTH-1:0]        len_q, len_d;
    logic [LEN_WIDTH-1:0]        issued_q, issued_d;
    logic [LEN_WIDTH-1:0]        delivered_q, delivered_d;
    logic [HBM_AWIDTH-1:0]       next_addr_q, next_addr_d;
    logic [HBM_AWIDTH-1:0]       addr_q, addr_d;
    logic                        avalid_q, avalid_d;
    logic [DISPATCHER_WIDTH-1:0] disp_cnt_q, disp_cnt_d;
    logic [CW-1:0]               out_q, out_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [PW-1:0]               wr_ptr_q, rd_ptr_q;
    logic [HBM_DWIDTH-1:0]       fifo_mem [MAX_OUTSTANDING];

    logic issue;
    logic pop;
    logic push;
    logic credit_ok;

    assign pop       = (cnt_q != '0) && disp_ready_i;
    // Only accept beats still owed to us; stray returns (e.g. after a reset abort) are dropped.
    assign push      = rsp_valid_i && (out_q != cnt_q);
    assign credit_ok = out_q < CW'(MAX_OUTSTANDING);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        issued_d    = issued_q;
        delivered_d = delivered_q;
        next_addr_d = next_addr_q;
        addr_d      = addr_q;
        disp_cnt_d  = disp_cnt_q;
        issue       = 1'b0;

        if (pop) begin
            delivered_d = delivered_q + LEN_WIDTH'(1);
            disp_cnt_d  = disp_cnt_q + DISPATCHER_WIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                if (start_acc_i) begin
                    len_d       = length_i;
                    issued_d    = '0;
                    delivered_d = '0;
                    disp_cnt_d  = '0;
                    next_addr_d = base_addr_i;
                    if (length_i == '0) begin
                        state_d = DONE_CH;
                    end else begin
                        state_d = ISSUE;
                        // First request goes out the cycle right after start when the controller allows it.
                        if (!ctrl_full_i && credit_ok) begin
                            issue       = 1'b1;
                            addr_d      = base_addr_i;
                            next_addr_d = base_addr_i + HBM_AWIDTH'(1);
                            issued_d    = LEN_WIDTH'(1);
                            if (length_i == LEN_WIDTH'(1)) begin
                                state_d = DRAIN;
                            end
                        end
                    end
                end
            end
            ISSUE: begin
                if (!ctrl_full_i && credit_ok) begin
                    issue       = 1'b1;
                    addr_d      = next_addr_q;
                    next_addr_d = next_addr_q + HBM_AWIDTH'(1);
                    issued_d    = issued_q + LEN_WIDTH'(1);
                    if (issued_q == len_q - LEN_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (delivered_q == len_q) begin
                    state_d = DONE_CH;
                end
            end
            DONE_CH: begin
                if (global_done_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        avalid_d = issue;

        case ({issue, pop})
            2'b10:   out_d = out_q + CW'(1);
            2'b01:   out_d = out_q - CW'(1);
            default: out_d = out_q;
        endcase

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
            next_addr_q <= '0;
            addr_q      <= '0;
            avalid_q    <= 1'b0;
            disp_cnt_q  <= '0;
            out_q       <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            delivered_q <= delivered_d;
            next_addr_q <= next_addr_d;
            addr_q      <= addr_d;
            avalid_q    <= avalid_d;
            disp_cnt_q  <= disp_cnt_d;
            out_q       <= out_d;
            cnt_q       <= cnt_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= rsp_data_i;
        end
    end

    assign ch_done_o      = (state_q == DONE_CH);
    assign req_addr_o     = addr_q;
    assign req_valid_o    = avalid_q;
    assign disp_valid_o   = (cnt_q != '0);
    assign disp_data_o    = disp_valid_o ? fifo_mem[rd_ptr_q] : '0;
    assign disp_counter_o = disp_cnt_q;

    a_no_orphan_beat: assert property (@(posedge clk) disable iff (!rst_n)
        !(rsp_valid_i && (out_q == '0)));

endmodule

// File: rtl/stream_loader.sv
// rtl/stream_loader.sv - multi-channel HBM burst loader with global start/busy/done control
module stream_loader
    import stream_loader_pkg::*;
#(
    parameter int CHANNEL_NUM      = 2,
    parameter int HBM_AWIDTH       = 28,
    parameter int HBM_DWIDTH       = 256,
    parameter int LEN_WIDTH        = 16,
    parameter int DISPATCHER_WIDTH = 1,
    parameter int MAX_OUTSTANDING  = DEFAULT_MAX_OUTSTANDING
) (
    input  logic                                  clk,
    input  logic                                  bram_rst_n,
    input  logic                                  start,
    input  logic [CHANNEL_NUM*HBM_AWIDTH-1:0]     base_addr,
    input  logic [LEN_WIDTH-1:0]                  length,
    output logic                                  busy,
    output logic                                  done,
    output logic [CHANNEL_NUM*HBM_AWIDTH-1:0]     hbm_controller_addr,
    output logic [CHANNEL_NUM-1:0]                hbm_addr_valid,
    input  logic [CHANNEL_NUM-1:0]                hbm_controller_full,
    input  logic [CHANNEL_NUM*HBM_DWIDTH-1:0]     hbm_controller_data,
    input  logic [CHANNEL_NUM-1:0]                hbm_data_valid,
    output logic [CHANNEL_NUM*HBM_DWIDTH-1:0]     dispatcher_data,
    output logic [CHANNEL_NUM*DISPATCHER_WIDTH-1:0] dispatcher_counter,
    output logic [CHANNEL_NUM-1:0]                dispatcher_valid,
    input  logic [CHANNEL_NUM-1:0]                dispatcher_ready
);

    logic                   busy_q, busy_d;
    logic                   start_acc;
    logic [CHANNEL_NUM-1:0] ch_done;

    // busy_q stays high through the done cycle so a start coinciding with done is ignored.
    assign start_acc = start && !busy_q;
    assign done      = &ch_done;
    assign busy      = busy_q && !done;

    always_comb begin
        busy_d = busy_q;
        if (done) begin
            busy_d = 1'b0;
        end else if (start_acc) begin
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge bram_rst_n) begin
        if (!bram_rst_n) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
        end
    end

    for (genvar g = 0; g < CHANNEL_NUM; g++) begin : g_ch
        stream_loader_channel #(
            .HBM_AWIDTH      (HBM_AWIDTH),
            .HBM_DWIDTH      (HBM_DWIDTH),
            .LEN_WIDTH       (LEN_WIDTH),
            .DISPATCHER_WIDTH(DISPATCHER_WIDTH),
            .MAX_OUTSTANDING (MAX_OUTSTANDING)
        ) u_channel (
            .clk           (clk),
            .rst_n         (bram_rst_n),
            .start_acc_i   (start_acc),
            .global_done_i (done),
            .base_addr_i   (base_addr[g*HBM_AWIDTH +: HBM_AWIDTH]),
            .length_i      (length),
            .ch_done_o     (ch_done[g]),
            .req_addr_o    (hbm_controller_addr[g*HBM_AWIDTH +: HBM_AWIDTH]),
            .req_valid_o   (hbm_addr_valid[g]),
            .ctrl_full_i   (hbm_controller_full[g]),
            .rsp_data_i    (hbm_controller_data[g*HBM_DWIDTH +: HBM_DWIDTH]),
            .rsp_valid_i   (hbm_data_valid[g]),
            .disp_data_o   (dispatcher_data[g*HBM_DWIDTH +: HBM_DWIDTH]),
            .disp_counter_o(dispatcher_counter[g*DISPATCHER_WIDTH +: DISPATCHER_WIDTH]),
            .disp_valid_o  (dispatcher_valid[g]),
            .disp_ready_i  (dispatcher_ready[g])
        );
    end

endmodule

// File: tb/tb_stream_loader.sv
// tb/tb_stream_loader.sv - scoreboard bench for stream_loader with a latency-3 controller model
module tb_stream_loader;

    localparam int CH  = 2;
    localparam int AW  = 12;
    localparam int DW  = 16;
    localparam int LW  = 8;
    localparam int DPW = 1;
    localparam int MO  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                bram_rst_n = 1'b0;
    logic                start = 1'b0;
    logic [CH*AW-1:0]    base_addr = '0;
    logic [LW-1:0]       length = '0;
    logic                busy, done;
    logic [CH*AW-1:0]    hbm_controller_addr;
    logic [CH-1:0]       hbm_addr_valid;
    logic [CH-1:0]       hbm_controller_full = '0;
    logic [CH*DW-1:0]    hbm_controller_data = '0;
    logic [CH-1:0]       hbm_data_valid = '0;
    logic [CH*DW-1:0]    dispatcher_data;
    logic [CH*DPW-1:0]   dispatcher_counter;
    logic [CH-1:0]       dispatcher_valid;
    logic [CH-1:0]       dispatcher_ready = '0;

    stream_loader #(
        .CHANNEL_NUM(CH), .HBM_AWIDTH(AW), .HBM_DWIDTH(DW), .LEN_WIDTH(LW),
        .DISPATCHER_WIDTH(DPW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .bram_rst_n(bram_rst_n), .start(start), .base_addr(base_addr),
        .length(length), .busy(busy), .done(done),
        .hbm_controller_addr(hbm_controller_addr), .hbm_addr_valid(hbm_addr_valid),
        .hbm_controller_full(hbm_controller_full), .hbm_controller_data(hbm_controller_data),
        .hbm_data_valid(hbm_data_valid), .dispatcher_data(dispatcher_data),
        .dispatcher_counter(dispatcher_counter), .dispatcher_valid(dispatcher_valid),
        .dispatcher_ready(dispatcher_ready)
    );

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } ret_t;

    int errors = 0;
    int checks = 0;

    logic [AW-1:0] exp_addr [CH][$];
    logic [DW-1:0] exp_data [CH][$];
    int            exp_cnt  [CH][$];
    ret_t          pend     [CH][$];

    int cyc = 0, start_cyc = 0, done_cnt = 0, done_rel = -1, win_reqs = 0;
    int req_cnt [CH];
    int first_rel [CH];
    int ready_pct = 100, full_pct = 0, full_lo = 1000, full_hi = -1;
    logic [CH-1:0] prev_full = '0;
    int   env_rel;
    ret_t env_ret;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input int c, input logic [AW-1:0] a);
        return {4'(c + 5), a};
    endfunction

    // Controller model, request/beat monitor and consumer, all at the negative edge.
    always @(negedge clk) begin
        cyc++;
        env_rel = cyc - start_cyc;
        if (!bram_rst_n) begin
            for (int c = 0; c < CH; c++) pend[c].delete();
            hbm_data_valid      = '0;
            hbm_controller_full = '0;
            dispatcher_ready    = '0;
            prev_full           = '0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (hbm_addr_valid[c]) begin
                    req_cnt[c]++;
                    if (first_rel[c] < 0) first_rel[c] = env_rel;
                    if (env_rel >= full_lo + 1 && env_rel <= full_hi + 1) win_reqs++;
                    chk("issue_after_full", prev_full[c], 0);
                    chk("req_expected", exp_addr[c].size() != 0, 1);
                    if (exp_addr[c].size() != 0)
                        chk("req_addr", hbm_controller_addr[c*AW +: AW], exp_addr[c].pop_front());
                    pend[c].push_back('{cyc + 3, mk_data(c, hbm_controller_addr[c*AW +: AW])});
                end
            end
            if (done) begin
                done_cnt++;
                done_rel = env_rel;
                chk("busy_at_done", busy, 0);
                for (int c = 0; c < CH; c++) chk("beats_left_at_done", exp_data[c].size(), 0);
            end
            for (int c = 0; c < CH; c++) begin
                hbm_data_valid[c] = 1'b0;
                if (pend[c].size() != 0 && pend[c][0].due <= cyc) begin
                    env_ret = pend[c].pop_front();
                    hbm_data_valid[c] = 1'b1;
                    hbm_controller_data[c*DW +: DW] = env_ret.data;
                end
                hbm_controller_full[c] = (env_rel >= full_lo && env_rel <= full_hi) ||
                                         ($urandom_range(99) < full_pct);
                prev_full[c] = hbm_controller_full[c];
                dispatcher_ready[c] = ($urandom_range(99) < ready_pct);
                if (dispatcher_valid[c] && dispatcher_ready[c]) begin
                    chk("beat_expected", exp_data[c].size() != 0, 1);
                    if (exp_data[c].size() != 0) begin
                        chk("beat_data", dispatcher_data[c*DW +: DW], exp_data[c].pop_front());
                        chk("beat_counter", dispatcher_counter[c*DPW +: DPW], exp_cnt[c].pop_front());
                    end
                end
            end
        end
    end

    task automatic clear_expect();
        for (int c = 0; c < CH; c++) begin
            exp_addr[c].delete();
            exp_data[c].delete();
            exp_cnt[c].delete();
        end
    endtask

    // Reference: channel c requests base_c + k (mod 2^AW) for k < len, beat k tagged k mod 2^DPW.
    task automatic launch(input logic [AW-1:0] b0, input logic [AW-1:0] b1, input int len);
        logic [AW-1:0] a;
        @(posedge clk); #2;
        base_addr = {b1, b0};
        length    = LW'(len);
        start     = 1'b1;
        start_cyc = cyc + 1;
        win_reqs  = 0;
        for (int c = 0; c < CH; c++) begin
            req_cnt[c]   = 0;
            first_rel[c] = -1;
            for (int k = 0; k < len; k++) begin
                a = AW'(((c == 0 ? int'(b0) : int'(b1)) + k) % (1 << AW));
                exp_addr[c].push_back(a);
                exp_data[c].push_back(mk_data(c, a));
                exp_cnt[c].push_back(k % (1 << DPW));
            end
        end
        @(posedge clk); #2;
        start = 1'b0;
        if (len != 0) chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("done_within_budget", done_cnt != d0, 1);
        repeat (3) @(posedge clk);
        chk("done_once", done_cnt - d0, 1);
        for (int c = 0; c < CH; c++) begin
            chk("addr_queue_empty", exp_addr[c].size(), 0);
            chk("beat_queue_empty", exp_data[c].size(), 0);
        end
        clear_expect();
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_addr_valid"}, hbm_addr_valid, 0);
        chk({tag, "_addr"}, hbm_controller_addr, 0);
        chk({tag, "_disp_valid"}, dispatcher_valid, 0);
        chk({tag, "_disp_data"}, dispatcher_data, 0);
        chk({tag, "_disp_counter"}, dispatcher_counter, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk_quiet("reset");
        bram_rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Basic run.
        launch(12'h100, 12'h200, 4);
        wait_done(200);
        for (int c = 0; c < CH; c++) chk("first_req_rel", first_rel[c], 1);

        // Credit exhaustion with a stalled consumer.
        ready_pct = 0;
        launch(12'h040, 12'h080, 10);
        repeat (30) @(posedge clk);
        for (int c = 0; c < CH; c++) chk("credit_stall_reqs", req_cnt[c], MO);
        ready_pct = 100;
        wait_done(300);
        for (int c = 0; c < CH; c++) chk("credit_total_reqs", req_cnt[c], 10);

        // Controller full for cycles 3..7.
        full_lo = 3;
        full_hi = 7;
        launch(12'h300, 12'h3F0, 8);
        wait_done(300);
        chk("full_window_reqs", win_reqs, 0);
        full_lo = 1000;
        full_hi = -1;

        // Address wrap.
        launch(12'hFFE, 12'hFFF, 3);
        wait_done(200);

        // Zero length.
        launch(12'h123, 12'h456, 0);
        wait_done(20);
        chk("len0_done_rel", done_rel, 1);
        for (int c = 0; c < CH; c++) chk("len0_reqs", req_cnt[c], 0);

        // Start while busy is ignored.
        launch(12'h500, 12'h600, 6);
        @(posedge clk); #2;
        base_addr = {12'h777, 12'h888};
        length    = LW'(9);
        start     = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done(300);
        for (int c = 0; c < CH; c++) chk("busy_start_reqs", req_cnt[c], 6);

        // Randomised runs.
        for (int i = 0; i < 6; i++) begin
            ready_pct = $urandom_range(100, 40);
            full_pct  = $urandom_range(30, 0);
            launch(AW'($urandom), AW'($urandom), $urandom_range(20, 1));
            wait_done(3000);
        end
        ready_pct = 100;
        full_pct  = 0;

        // Reset in DRAIN, then a fresh run.
        ready_pct = 0;
        launch(12'h0A0, 12'h0B0, 4);
        repeat (12) @(posedge clk);
        #2;
        bram_rst_n = 1'b0;
        #1;
        chk_quiet("midreset");
        clear_expect();
        repeat (2) @(posedge clk);
        #2;
        bram_rst_n = 1'b1;
        ready_pct = 100;
        launch(12'h0C0, 12'h0D0, 5);
        wait_done(300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
